game_session_ctrl: RTL and testbench



---
 rtl/game_session_ctrl_if.sv | 49 ++++
 rtl/game_session_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_game_session_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/game_session_ctrl_if.sv
// Session controller bus: game-core events in, session status out.
// master drives events; slave is the session controller.
interface game_session_ctrl_if;

  logic       frame_tick;
  logic       start_pulse;
  logic       pause_pulse;
  logic       ball_lost;
  logic       bricks_cleared;

  logic       game_active;
  logic       serve_hold;
  logic       level_load;
  logic [1:0] level_num;
  logic [2:0] lives;
  logic [1:0] scene_sel;
  logic [2:0] state_leds;

  modport master (
    output frame_tick,
    output start_pulse,
    output pause_pulse,
    output ball_lost,
    output bricks_cleared,
    input  game_active,
    input  serve_hold,
    input  level_load,
    input  level_num,
    input  lives,
    input  scene_sel,
    input  state_leds
  );

  modport slave (
    input  frame_tick,
    input  start_pulse,
    input  pause_pulse,
    input  ball_lost,
    input  bricks_cleared,
    output game_active,
    output serve_hold,
    output level_load,
    output level_num,
    output lives,
    output scene_sel,
    output state_leds
  );

endinterface

// File: rtl/game_session_ctrl.sv
// Breakout session sequencer: lives, levels, serve countdown, end scenes.
// Optional pause state enabled by defining GAME_PAUSE_EN.
module game_session_ctrl #(
  parameter int LIVES_INIT   = 3,
  parameter int NUM_LEVELS   = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int END_FRAMES   = 300
) (
  input  logic                i_vga_clk,
  input  logic                i_sys_rst,
  game_session_ctrl_if.slave  io_sess
);

  localparam logic [2:0] ST_START = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SERVE = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_WIN   = 3'd4;
  localparam logic [2:0] ST_LOSE  = 3'd5;
`ifdef GAME_PAUSE_EN
  localparam logic [2:0] ST_PAUSE = 3'd6;
`endif

  localparam logic [2:0] LIVES_N  = 3'(LIVES_INIT);
  localparam logic [1:0] LVL_LAST = 2'(NUM_LEVELS - 1);
  localparam logic [9:0] SRV_N    = 10'(SERVE_FRAMES);
  localparam logic [9:0] END_N    = 10'(END_FRAMES);

  logic [2:0] r_state;
  logic [9:0] r_frame_cnt;
  logic [2:0] r_lives;
  logic [1:0] r_level;
  logic       r_game_active;
  logic       r_serve_hold;
  logic       r_level_load;
  logic [1:0] r_scene_sel;
  logic [2:0] r_state_leds;

  logic [2:0] w_nxt_state;
  logic [9:0] w_nxt_cnt;
  logic [2:0] w_nxt_lives;
  logic [1:0] w_nxt_level;
  logic [9:0] w_cnt_inc;

  logic       w_game_active;
  logic       w_serve_hold;
  logic       w_level_load;
  logic [1:0] w_scene_sel;
  logic [2:0] w_state_leds;

`ifdef GAME_PAUSE_EN
  logic       r_saved_serve;
  logic       w_nxt_saved;
`else
  logic       w_unused_pause;
  assign w_unused_pause = io_sess.pause_pulse;
`endif

  // saturating frame counter increment
  assign w_cnt_inc = (r_frame_cnt == 10'h3FF) ?
                     r_frame_cnt : r_frame_cnt + 10'd1;

  // next-state and session bookkeeping; pause wins over same-cycle events
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_frame_cnt;
    w_nxt_lives = r_lives;
    w_nxt_level = r_level;
`ifdef GAME_PAUSE_EN
    w_nxt_saved = r_saved_serve;
`endif
    unique case (1'b1)
      (r_state == ST_START): begin
        if (io_sess.start_pulse) begin
          w_nxt_state = ST_LOAD;
          w_nxt_lives = LIVES_N;
          w_nxt_level = 2'd0;
          w_nxt_cnt   = 10'd0;
        end
      end
      (r_state == ST_LOAD): begin
        w_nxt_state = ST_SERVE;
        w_nxt_cnt   = 10'd0;
      end
      (r_state == ST_SERVE): begin
`ifdef GAME_PAUSE_EN
        if (io_sess.pause_pulse) begin
          w_nxt_state = ST_PAUSE;
          w_nxt_saved = 1'b1;
        end else
`endif
        if (io_sess.frame_tick) begin
          if (w_cnt_inc >= SRV_N) begin
            w_nxt_state = ST_PLAY;
            w_nxt_cnt   = 10'd0;
          end else begin
            w_nxt_cnt   = w_cnt_inc;
          end
        end
      end
      (r_state == ST_PLAY): begin
`ifdef GAME_PAUSE_EN
        if (io_sess.pause_pulse) begin
          w_nxt_state = ST_PAUSE;
          w_nxt_saved = 1'b0;
        end else
`endif
        if (io_sess.bricks_cleared) begin
          w_nxt_cnt = 10'd0;
          if (r_level >= LVL_LAST) begin
            w_nxt_state = ST_WIN;
          end else begin
            w_nxt_state = ST_LOAD;
            w_nxt_level = r_level + 2'd1;
          end
        end else if (io_sess.ball_lost) begin
          w_nxt_cnt = 10'd0;
          if (r_lives <= 3'd1) begin
            w_nxt_state = ST_LOSE;
            w_nxt_lives = 3'd0;
          end else begin
            w_nxt_state = ST_SERVE;
            w_nxt_lives = r_lives - 3'd1;
          end
        end
      end
      (r_state == ST_WIN) ||
      (r_state == ST_LOSE): begin
        if (io_sess.start_pulse) begin
          w_nxt_state = ST_START;
          w_nxt_cnt   = 10'd0;
        end else if (io_sess.frame_tick) begin
          if (w_cnt_inc >= END_N) begin
            w_nxt_state = ST_START;
            w_nxt_cnt   = 10'd0;
          end else begin
            w_nxt_cnt   = w_cnt_inc;
          end
        end
      end
`ifdef GAME_PAUSE_EN
      (r_state == ST_PAUSE): begin
        if (io_sess.pause_pulse) begin
          w_nxt_state = r_saved_serve ?
                        ST_SERVE : ST_PLAY;
        end
      end
`endif
      default: begin
        w_nxt_state = ST_START;
        w_nxt_cnt   = 10'd0;
      end
    endcase
  end

  // output decode from the next state so outputs register with it
  always_comb begin
    w_game_active = 1'b0;
    w_serve_hold  = 1'b0;
    w_level_load  = 1'b0;
    w_scene_sel   = 2'b00;
    w_state_leds  = 3'b001;
    unique case (1'b1)
      (w_nxt_state == ST_LOAD): begin
        w_level_load  = 1'b1;
        w_scene_sel   = 2'b01;
        w_state_leds  = 3'b010;
      end
      (w_nxt_state == ST_SERVE): begin
        w_game_active = 1'b1;
        w_serve_hold  = 1'b1;
        w_scene_sel   = 2'b01;
        w_state_leds  = 3'b010;
      end
      (w_nxt_state == ST_PLAY): begin
        w_game_active = 1'b1;
        w_scene_sel   = 2'b01;
        w_state_leds  = 3'b010;
      end
      (w_nxt_state == ST_WIN): begin
        w_scene_sel   = 2'b10;
        w_state_leds  = 3'b100;
      end
      (w_nxt_state == ST_LOSE): begin
        w_scene_sel   = 2'b11;
        w_state_leds  = 3'b101;
      end
`ifdef GAME_PAUSE_EN
      (w_nxt_state == ST_PAUSE): begin
        w_serve_hold  = w_nxt_saved;
        w_scene_sel   = 2'b01;
        w_state_leds  = 3'b010;
      end
`endif
      default: begin
        w_scene_sel   = 2'b00;
        w_state_leds  = 3'b001;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge i_vga_clk) begin
    if (i_sys_rst) begin
      r_state       <= ST_START;
      r_frame_cnt   <= 10'd0;
      r_lives       <= LIVES_N;
      r_level       <= 2'd0;
      r_game_active <= 1'b0;
      r_serve_hold  <= 1'b0;
      r_level_load  <= 1'b0;
      r_scene_sel   <= 2'b00;
      r_state_leds  <= 3'b001;
    end else begin
      r_state       <= w_nxt_state;
      r_frame_cnt   <= w_nxt_cnt;
      r_lives       <= w_nxt_lives;
      r_level       <= w_nxt_level;
      r_game_active <= w_game_active;
      r_serve_hold  <= w_serve_hold;
      r_level_load  <= w_level_load;
      r_scene_sel   <= w_scene_sel;
      r_state_leds  <= w_state_leds;
    end
  end

`ifdef GAME_PAUSE_EN
  // remembers whether pause was entered from the serve countdown
  always_ff @(posedge i_vga_clk) begin
    if (i_sys_rst) begin
      r_saved_serve <= 1'b0;
    end else begin
      r_saved_serve <= w_nxt_saved;
    end
  end
`endif

  assign io_sess.game_active = r_game_active;
  assign io_sess.serve_hold  = r_serve_hold;
  assign io_sess.level_load  = r_level_load;
  assign io_sess.level_num   = r_level;
  assign io_sess.lives       = r_lives;
  assign io_sess.scene_sel   = r_scene_sel;
  assign io_sess.state_leds  = r_state_leds;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed scoreboard bench for game_session_ctrl.
// Pause scenarios run when GAME_PAUSE_EN is defined.
module tb_game_session_ctrl;

  logic clk;
  logic rst;

  game_session_ctrl_if bus ();

  game_session_ctrl #(
    .LIVES_INIT   (3),
    .NUM_LEVELS   (3),
    .SERVE_FRAMES (60),
    .END_FRAMES   (300)
  ) dut (
    .i_vga_clk (clk),
    .i_sys_rst (rst),
    .io_sess   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] E_NO = 5'b00000;
  localparam logic [4:0] E_ST = 5'b10000;
  localparam logic [4:0] E_PA = 5'b01000;
  localparam logic [4:0] E_BL = 5'b00100;
  localparam logic [4:0] E_BC = 5'b00010;
  localparam logic [4:0] E_TK = 5'b00001;

  int n_total = 0;
  int n_bad   = 0;

  logic [12:0] q_exp [$];
  string       q_tag [$];

  logic [12:0] w_obs;
  assign w_obs = {bus.game_active, bus.serve_hold,
                  bus.level_load, bus.level_num,
                  bus.lives, bus.scene_sel,
                  bus.state_leds};

  function automatic logic [12:0] mk(
    input logic ga, input logic sh, input logic ll,
    input logic [1:0] lvl, input logic [2:0] lv,
    input logic [1:0] sc, input logic [2:0] leds);
    return {ga, sh, ll, lvl, lv, sc, leds};
  endfunction

  function automatic logic [12:0] f_start(
    input logic [2:0] lv, input logic [1:0] lvl);
    return mk(0, 0, 0, lvl, lv, 2'b00, 3'b001);
  endfunction

  function automatic logic [12:0] f_load(
    input logic [2:0] lv, input logic [1:0] lvl);
    return mk(0, 0, 1, lvl, lv, 2'b01, 3'b010);
  endfunction

  function automatic logic [12:0] f_serve(
    input logic [2:0] lv, input logic [1:0] lvl);
    return mk(1, 1, 0, lvl, lv, 2'b01, 3'b010);
  endfunction

  function automatic logic [12:0] f_play(
    input logic [2:0] lv, input logic [1:0] lvl);
    return mk(1, 0, 0, lvl, lv, 2'b01, 3'b010);
  endfunction

  function automatic logic [12:0] f_win(
    input logic [2:0] lv, input logic [1:0] lvl);
    return mk(0, 0, 0, lvl, lv, 2'b10, 3'b100);
  endfunction

  function automatic logic [12:0] f_lose(
    input logic [2:0] lv, input logic [1:0] lvl);
    return mk(0, 0, 0, lvl, lv, 2'b11, 3'b101);
  endfunction

  function automatic logic [12:0] f_pause(
    input logic sh, input logic [2:0] lv,
    input logic [1:0] lvl);
    return mk(0, sh, 0, lvl, lv, 2'b01, 3'b010);
  endfunction

  task automatic step(input logic [4:0] ev);
    {bus.start_pulse, bus.pause_pulse, bus.ball_lost,
     bus.bricks_cleared, bus.frame_tick} = ev;
    @(posedge clk);
    #1;
    {bus.start_pulse, bus.pause_pulse, bus.ball_lost,
     bus.bricks_cleared, bus.frame_tick} = 5'b00000;
  endtask

  task automatic chk();
    logic [12:0] e;
    string t;
    if (q_exp.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL scoreboard_empty obs=%h exp=none", w_obs);
    end else begin
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      n_total++;
      assert (w_obs === e) else begin
        n_bad++;
        $error("FAIL %s obs=%h exp=%h", t, w_obs, e);
      end
    end
  endtask

  task automatic st(input logic [4:0] ev,
                    input string tag,
                    input logic [12:0] e);
    q_exp.push_back(e);
    q_tag.push_back(tag);
    step(ev);
    chk();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(E_TK);
      step(E_NO);
    end
  endtask

  initial begin
    rst = 1'b1;
    {bus.start_pulse, bus.pause_pulse, bus.ball_lost,
     bus.bricks_cleared, bus.frame_tick} = 5'b00000;
    step(E_NO);
    st(E_NO, "reset", f_start(3, 0));
    rst = 1'b0;
    st(E_BL, "start_ign_lost", f_start(3, 0));

    st(E_ST, "load_pulse", f_load(3, 0));
    st(E_NO, "load_one_cycle", f_serve(3, 0));
    ticks(59);
    st(E_NO, "serve_59", f_serve(3, 0));
    st(E_TK, "serve_done", f_play(3, 0));
    st(E_ST, "play_ign_start", f_play(3, 0));
`ifndef GAME_PAUSE_EN
    st(E_PA, "play_ign_pause", f_play(3, 0));
`endif

    st(E_BL, "lost_1", f_serve(2, 0));
    ticks(60);
    st(E_NO, "reserve_play", f_play(2, 0));
    st(E_BL | E_BC, "both_events", f_load(2, 1));
    st(E_NO, "lvl1_serve", f_serve(2, 1));
    ticks(60);
    st(E_NO, "lvl1_play", f_play(2, 1));
    st(E_BC, "clear_lvl1", f_load(2, 2));
    st(E_NO, "lvl2_serve", f_serve(2, 2));
    ticks(60);
    st(E_NO, "lvl2_play", f_play(2, 2));
    st(E_BC, "clear_last", f_win(2, 2));
    st(E_BL, "win_ign_lost", f_win(2, 2));
    ticks(299);
    st(E_NO, "win_299", f_win(2, 2));
    st(E_TK, "win_timeout", f_start(2, 2));

    st(E_ST, "g2_load", f_load(3, 0));
    st(E_NO, "g2_serve", f_serve(3, 0));
    ticks(60);
    st(E_BL, "g2_lost1", f_serve(2, 0));
    ticks(60);
    st(E_BL, "g2_lost2", f_serve(1, 0));
    ticks(60);
    st(E_BL, "g2_lost3", f_lose(0, 0));
    st(E_BL, "lose_no_underflow", f_lose(0, 0));
    ticks(5);
    st(E_NO, "lose_5", f_lose(0, 0));
    st(E_ST, "lose_start_exit", f_start(0, 0));

    st(E_ST, "g3_load", f_load(3, 0));
    st(E_NO, "g3_serve", f_serve(3, 0));
    ticks(60);
    st(E_BL, "g3_lost", f_serve(2, 0));
    rst = 1'b1;
    st(E_NO, "reset_mid", f_start(3, 0));
    rst = 1'b0;

`ifdef GAME_PAUSE_EN
    st(E_ST, "p_load", f_load(3, 0));
    st(E_NO, "p_serve", f_serve(3, 0));
    ticks(20);
    st(E_PA, "pause_serve", f_pause(1, 3, 0));
    ticks(50);
    st(E_BC, "pause_ign_bc", f_pause(1, 3, 0));
    st(E_BL, "pause_ign_bl", f_pause(1, 3, 0));
    st(E_PA, "unpause_serve", f_serve(3, 0));
    ticks(39);
    st(E_NO, "resume_39", f_serve(3, 0));
    st(E_TK, "resume_play", f_play(3, 0));
    st(E_PA, "pause_play", f_pause(0, 3, 0));
    st(E_PA, "unpause_play", f_play(3, 0));
    st(E_BL, "p_lost", f_serve(2, 0));
    st(E_PA, "pause_again", f_pause(1, 2, 0));
    rst = 1'b1;
    st(E_NO, "reset_pause", f_start(3, 0));
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
